// File: rtl/irq_collector_if.sv
// ==== irq_collector_if : push-side handshake between irq_collector and the word FIFO (rev 1.0) ====
`default_nettype none

interface irq_collector_if #(
  parameter int DBITS = 32
) ();
  logic             fifo_wr;
  logic [DBITS-1:0] fifo_din;
  logic             fifo_full;

  modport master (
    output fifo_wr,
    output fifo_din,
    input  fifo_full
  );

  modport slave (
    input  fifo_wr,
    input  fifo_din,
    output fifo_full
  );
endinterface

`default_nettype wire

// File: rtl/irq_collector.sv
// ==== irq_collector : edge capture, round-robin arbitration, pulse-then-release FIFO push (rev 1.0) ====
`default_nettype none

module irq_collector #(
  parameter int NIRQ  = 8,
  parameter int DBITS = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [NIRQ-1:0] irq_mask,
  irq_collector_if.master fifo,
  output logic            busy,
  output logic [NIRQ-1:0] pending,
  output logic [7:0]      coalesce_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    HOLD1  = 2'd2,
    HOLD2  = 2'd3
  } state_t;

  state_t          state;
  logic [NIRQ-1:0] s1, s2, s3;
  logic [NIRQ-1:0] edges;
  logic [NIRQ-1:0] clr;
  logic [15:0]     ts;
  logic [7:0]      rr_ptr;
  logic [7:0]      grant_idx;
  logic [7:0]      rr_next;
  logic            found;
  logic            do_grant;
  logic            coalesce_hit;

  assign edges    = s2 & ~s3 & ~irq_mask;
  assign do_grant = (state == IDLE) && (|pending) && !fifo.fifo_full;
  assign rr_next  = (grant_idx == 8'(NIRQ - 1)) ? 8'd0 : grant_idx + 8'd1;

  // Two passes: lines at or above rr_ptr first, then the wrapped lower part.
  always_comb begin
    found     = 1'b0;
    grant_idx = 8'd0;
    for (int j = 0; j < NIRQ; j++) begin
      if (!found && pending[j] && (j >= int'(rr_ptr))) begin
        found     = 1'b1;
        grant_idx = 8'(j);
      end
    end
    for (int j = 0; j < NIRQ; j++) begin
      if (!found && pending[j]) begin
        found     = 1'b1;
        grant_idx = 8'(j);
      end
    end
  end

  always_comb begin
    clr = '0;
    for (int j = 0; j < NIRQ; j++) begin
      clr[j] = do_grant && (grant_idx == 8'(j));
    end
  end

  // A set landing on the line being cleared wins and is not a merge.
  assign coalesce_hit = |(edges & pending & ~clr);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1           <= '0;
      s2           <= '0;
      s3           <= '0;
      pending      <= '0;
      coalesce_cnt <= 8'd0;
      ts           <= 16'd0;
    end else begin
      s1      <= irq_in;
      s2      <= s1;
      s3      <= s2;
      ts      <= ts + 16'd1;
      pending <= (pending & ~clr) | edges;
      if (do_grant) begin
        coalesce_cnt <= {7'd0, coalesce_hit};
      end else if (coalesce_hit && (coalesce_cnt != 8'hFF)) begin
        coalesce_cnt <= coalesce_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      fifo.fifo_wr  <= 1'b0;
      fifo.fifo_din <= '0;
      busy          <= 1'b0;
      rr_ptr        <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (do_grant) begin
            fifo.fifo_din <= DBITS'({ts, coalesce_cnt, grant_idx});
            rr_ptr        <= rr_next;
            fifo.fifo_wr  <= 1'b1;
            busy          <= 1'b1;
            state         <= STROBE;
          end
        end
        STROBE: begin
          fifo.fifo_wr <= 1'b0;
          state        <= HOLD1;
        end
        HOLD1: begin
          state <= HOLD2;
        end
        HOLD2: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          fifo.fifo_wr <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_collector.sv
// ==== tb_irq_collector : scoreboard bench for irq_collector (rev 1.0) ====
`default_nettype none

module tb_irq_collector;
  localparam int NIRQ = 8;

  logic            clock   = 1'b0;
  logic            reset_n = 1'b0;
  logic [NIRQ-1:0] irq_in  = '0;
  logic [NIRQ-1:0] irq_mask = '0;
  logic            busy;
  logic [NIRQ-1:0] pending;
  logic [7:0]      coalesce_cnt;

  irq_collector_if #(.DBITS(32)) bus ();

  irq_collector #(.NIRQ(NIRQ), .DBITS(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .irq_in       (irq_in),
    .irq_mask     (irq_mask),
    .fifo         (bus),
    .busy         (busy),
    .pending      (pending),
    .coalesce_cnt (coalesce_cnt)
  );

  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] ts_m     = 16'd0;

  // Reference timestamp: cleared by a reset edge, otherwise +1 per edge.
  always @(posedge clock) begin
    cyc  <= cyc + 1;
    ts_m <= reset_n ? ts_m + 16'd1 : 16'd0;
  end

  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input logic [NIRQ-1:0] lines);
    irq_in = lines;
    @(negedge clock);
    irq_in = '0;
    @(negedge clock);
  endtask

  task automatic wait_push(input string tag, output int rise_cyc, output logic [31:0] word);
    exp_t e;
    int   n;
    n        = 0;
    rise_cyc = -1;
    word     = '0;
    while (bus.fifo_wr !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_wr_seen"}, 32'(bus.fifo_wr), 32'd1);
    if (bus.fifo_wr !== 1'b1) return;
    rise_cyc = cyc;
    word     = bus.fifo_din;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_idx"},   32'(word[7:0]),   32'(e.idx));
    chk({tag, "_cnt"},   32'(word[15:8]),  32'(e.cnt));
    chk({tag, "_ts"},    32'(word[31:16]), 32'(ts_m - 16'd1));
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    @(negedge clock);
    chk({tag, "_wr_1cyc"}, 32'(bus.fifo_wr), 32'd0);
    chk({tag, "_busy1"},   32'(busy), 32'd1);
    chk({tag, "_hold1"},   bus.fifo_din, word);
    @(negedge clock);
    chk({tag, "_busy2"}, 32'(busy), 32'd1);
    chk({tag, "_hold2"}, bus.fifo_din, word);
    @(negedge clock);
    chk({tag, "_idle"},  32'(busy), 32'd0);
  endtask

  initial begin
    int          r0, r1, r2, r3, n;
    logic [31:0] w;

    // Reset held three cycles with every request line high.
    bus.fifo_full = 1'b0;
    irq_in        = 8'hFF;
    reset_n       = 1'b0;
    tick(3);
    chk("rst_wr",      32'(bus.fifo_wr), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_cnt",     32'(coalesce_cnt), 32'd0);
    chk("rst_din",     bus.fifo_din, 32'd0);
    irq_in = '0;
    tick(3);
    reset_n = 1'b1;
    tick(4);
    chk("post_rst_pending", 32'(pending), 32'd0);
    chk("post_rst_wr",      32'(bus.fifo_wr), 32'd0);

    // Single event on line 5, with latency from drive to strobe.
    sbq.push_back('{idx: 8'd5, cnt: 8'd0});
    r0 = cyc;
    pulse(8'h20);
    wait_push("single", r1, w);
    chk("single_latency", 32'(r1 - r0), 32'd4);
    chk("single_pending", 32'(pending), 32'd0);

    // Line 2 alone moves the pointer to 3, then 2/6/0 together.
    sbq.push_back('{idx: 8'd2, cnt: 8'd0});
    pulse(8'h04);
    wait_push("rr_setup", r0, w);
    sbq.push_back('{idx: 8'd6, cnt: 8'd0});
    sbq.push_back('{idx: 8'd0, cnt: 8'd0});
    sbq.push_back('{idx: 8'd2, cnt: 8'd0});
    pulse(8'h45);
    wait_push("rr_a", r1, w);
    wait_push("rr_b", r2, w);
    wait_push("rr_c", r3, w);
    chk("rr_gap_ab", 32'(r2 - r1), 32'd4);
    chk("rr_gap_bc", 32'(r3 - r2), 32'd4);

    // Back-pressure: three edges on line 1 while full.
    bus.fifo_full = 1'b1;
    pulse(8'h02);
    pulse(8'h02);
    pulse(8'h02);
    tick(3);
    chk("full_wr",      32'(bus.fifo_wr), 32'd0);
    chk("full_busy",    32'(busy), 32'd0);
    chk("full_pending", 32'(pending), 32'h02);
    chk("full_cnt",     32'(coalesce_cnt), 32'd2);
    sbq.push_back('{idx: 8'd1, cnt: 8'd2});
    bus.fifo_full = 1'b0;
    wait_push("full_rel", r0, w);
    chk("full_cnt_cleared", 32'(coalesce_cnt), 32'd0);
    chk("full_pending_clr", 32'(pending), 32'd0);

    // Masked edges are ignored but an already-latched event still pushes.
    bus.fifo_full = 1'b1;
    pulse(8'h40);
    tick(1);
    irq_mask = 8'h40;
    pulse(8'h40);
    pulse(8'h40);
    tick(2);
    chk("mask_pending", 32'(pending), 32'h40);
    chk("mask_cnt",     32'(coalesce_cnt), 32'd0);
    sbq.push_back('{idx: 8'd6, cnt: 8'd0});
    bus.fifo_full = 1'b0;
    wait_push("mask_push", r0, w);
    irq_mask = '0;

    // Saturation after 300 edges, then a grant timed onto the ts wrap.
    bus.fifo_full = 1'b1;
    repeat (300) pulse(8'h10);
    tick(2);
    chk("sat_cnt",     32'(coalesce_cnt), 32'hFF);
    chk("sat_pending", 32'(pending), 32'h10);
    n = 0;
    while (ts_m != 16'd0 && n < 70000) begin
      @(negedge clock);
      n++;
    end
    sbq.push_back('{idx: 8'd4, cnt: 8'hFF});
    bus.fifo_full = 1'b0;
    wait_push("wrap", r0, w);
    chk("wrap_ts_zero", 32'(w[31:16]), 32'd0);

    // Reset while the sequence sits in HOLD1.
    pulse(8'h88);
    n = 0;
    while (bus.fifo_wr !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("rst_mid_wr_seen", 32'(bus.fifo_wr), 32'd1);
    chk("rst_mid_idx7",    32'(bus.fifo_din[7:0]), 32'd7);
    @(negedge clock);
    chk("rst_mid_hold1_busy", 32'(busy), 32'd1);
    chk("rst_mid_pending3",   32'(pending), 32'h08);
    reset_n = 1'b0;
    @(negedge clock);
    chk("rst_mid_busy",    32'(busy), 32'd0);
    chk("rst_mid_wr",      32'(bus.fifo_wr), 32'd0);
    chk("rst_mid_pending", 32'(pending), 32'd0);
    reset_n = 1'b1;
    tick(2);
    chk("rst_mid_stays_idle", 32'(bus.fifo_wr), 32'd0);
    sbq.push_back('{idx: 8'd3, cnt: 8'd0});
    pulse(8'h08);
    wait_push("after_rst", r0, w);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
